// File: rtl/comb_logic_unit.sv
// comb_logic_unit: registered bundle of small logic functions.
// Provides a W-bit gate bank (inv/and/or/xor/nand/nor), an N-input AND
// reduction and a 4:1 mux. Every result passes through one output register,
// so all outputs change together, free of glitches, one cycle after their
// inputs are sampled.
// Optional feature: define COMB_PARITY_EN to build a registered XOR
// reduction of operand a on ypar; otherwise ypar is tied to 0.
module comb_logic_unit #(
    parameter int W = 4,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [N-1:0] d8,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   s,
    output logic [W-1:0] yinv,
    output logic [W-1:0] yand,
    output logic [W-1:0] yor,
    output logic [W-1:0] yxor,
    output logic [W-1:0] ynand,
    output logic [W-1:0] ynor,
    output logic         y8,
    output logic [W-1:0] ymux,
    output logic         ypar
);

    logic [W-1:0] muxsel;

    // Decode the mux select; every select value maps to exactly one input.
    always_comb begin
        muxsel = d0;
        case (s)
            2'b00:   muxsel = d0;
            2'b01:   muxsel = d1;
            2'b10:   muxsel = d2;
            2'b11:   muxsel = d3;
            default: muxsel = d0;
        endcase
    end

    // Capture all gate, reduction and mux results; reset clears them to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            yinv  <= '0;
            yand  <= '0;
            yor   <= '0;
            yxor  <= '0;
            ynand <= '0;
            ynor  <= '0;
            y8    <= 1'b0;
            ymux  <= '0;
        end else begin
            yinv  <= ~a;
            yand  <= a & b;
            yor   <= a | b;
            yxor  <= a ^ b;
            ynand <= ~(a & b);
            ynor  <= ~(a | b);
            y8    <= &d8;
            ymux  <= muxsel;
        end
    end

`ifdef COMB_PARITY_EN
    // Register the parity of operand a alongside the other results.
    always_ff @(posedge clk) begin
        if (reset) begin
            ypar <= 1'b0;
        end else begin
            ypar <= ^a;
        end
    end
`else
    assign ypar = 1'b0;
`endif

endmodule

// File: tb/tb_comb_logic_unit.sv
// Testbench for comb_logic_unit: directed vectors plus model-driven sweeps.
// Expected results are queued when stimulus is driven; a monitor pops and
// compares one entry after every rising edge.
module tb_comb_logic_unit;

    typedef struct packed {
        logic [3:0] yinv;
        logic [3:0] yand;
        logic [3:0] yor;
        logic [3:0] yxor;
        logic [3:0] ynand;
        logic [3:0] ynor;
        logic       y8;
        logic [3:0] ymux;
        logic       ypar;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] a, b, d0, d1, d2, d3;
    logic [7:0] d8;
    logic [1:0] s;
    logic [3:0] yinv, yand, yor, yxor, ynand, ynor, ymux;
    logic       y8, ypar;

    exp_t expQueue[$];
    int   checkCount = 0;
    int   failCount  = 0;

`ifdef COMB_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    comb_logic_unit #(.W(4), .N(8)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .d8(d8),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .s(s),
        .yinv(yinv), .yand(yand), .yor(yor), .yxor(yxor),
        .ynand(ynand), .ynor(ynor), .y8(y8), .ymux(ymux), .ypar(ypar)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model built from per-bit truth tables.
    function automatic exp_t modelOut(input logic [3:0] ma, mb, input logic [7:0] md8,
                                      input logic [3:0] m0, m1, m2, m3, input logic [1:0] ms);
        exp_t e;
        logic allOnes;
        logic odd;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            e.yand[i]  = (ma[i] == 1'b1 && mb[i] == 1'b1);
            e.yor[i]   = (ma[i] == 1'b1 || mb[i] == 1'b1);
            e.yxor[i]  = (ma[i] != mb[i]);
            e.yinv[i]  = (ma[i] == 1'b0);
            e.ynand[i] = !(ma[i] == 1'b1 && mb[i] == 1'b1);
            e.ynor[i]  = (ma[i] == 1'b0 && mb[i] == 1'b0);
        end
        allOnes = 1'b1;
        for (int i = 0; i < 8; i++) if (md8[i] == 1'b0) allOnes = 1'b0;
        e.y8 = allOnes;
        if (ms == 2'd0) e.ymux = m0;
        else if (ms == 2'd1) e.ymux = m1;
        else if (ms == 2'd2) e.ymux = m2;
        else e.ymux = m3;
        odd = 1'b0;
        for (int i = 0; i < 4; i++) if (ma[i] == 1'b1) odd = !odd;
        e.ypar = odd & PAR_ON;
        return e;
    endfunction

    // Drive one input set before the next rising edge and queue its expectation.
    task automatic applyStimulus(input logic rst, input logic [3:0] ta, tb,
                                 input logic [7:0] td8, input logic [3:0] t0, t1, t2, t3,
                                 input logic [1:0] ts, input exp_t e);
        @(negedge clk);
        reset = rst; a = ta; b = tb; d8 = td8;
        d0 = t0; d1 = t1; d2 = t2; d3 = t3; s = ts;
        expQueue.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: after each rising edge, compare outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQueue.size() > 0) begin
                e = expQueue.pop_front();
                checkOutput("yinv",  yinv,  e.yinv);
                checkOutput("yand",  yand,  e.yand);
                checkOutput("yor",   yor,   e.yor);
                checkOutput("yxor",  yxor,  e.yxor);
                checkOutput("ynand", ynand, e.ynand);
                checkOutput("ynor",  ynor,  e.ynor);
                checkOutput("y8",    {3'b0, y8},   {3'b0, e.y8});
                checkOutput("ymux",  ymux,  e.ymux);
                checkOutput("ypar",  {3'b0, ypar}, {3'b0, e.ypar});
            end
        end
    end

    // Stimulus sequence.
    initial begin
        exp_t e;
        reset = 1'b1; a = '0; b = '0; d8 = '0; d0 = '0; d1 = '0; d2 = '0; d3 = '0; s = '0;

        // Reset with all-ones style inputs: every output must be 0.
        applyStimulus(1'b1, 4'hF, 4'h0, 8'hFF, 4'h0, 4'h1, 4'h2, 4'h3, 2'd3, '0);
        e = '{yinv:4'h0, yand:4'h0, yor:4'hF, yxor:4'hF, ynand:4'hF, ynor:4'h0,
              y8:1'b1, ymux:4'h3, ypar:1'b0};
        applyStimulus(1'b0, 4'hF, 4'h0, 8'hFF, 4'h0, 4'h1, 4'h2, 4'h3, 2'd3, e);

        // Gate bank reference vector.
        e = '{yinv:4'b1010, yand:4'b0001, yor:4'b0111, yxor:4'b0110, ynand:4'b1110,
              ynor:4'b1000, y8:1'b1, ymux:4'h0, ypar:1'b0};
        applyStimulus(1'b0, 4'b0101, 4'b0011, 8'hFF, 4'h0, 4'h1, 4'h2, 4'h3, 2'd0, e);

        // AND reduction boundaries with one zero bit at each end, and all zeros.
        e = '{yinv:4'hF, yand:4'h0, yor:4'h0, yxor:4'h0, ynand:4'hF, ynor:4'hF,
              y8:1'b0, ymux:4'h1, ypar:1'b0};
        applyStimulus(1'b0, 4'h0, 4'h0, 8'hFE, 4'h0, 4'h1, 4'h2, 4'h3, 2'd1, e);
        applyStimulus(1'b0, 4'h0, 4'h0, 8'h7F, 4'h0, 4'h1, 4'h2, 4'h3, 2'd1, e);
        e.ymux = 4'h2;
        applyStimulus(1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 4'h1, 4'h2, 4'h3, 2'd2, e);
        e.ymux = 4'h3;
        applyStimulus(1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 4'h1, 4'h2, 4'h3, 2'd3, e);

        // Latency/throughput: a changes every cycle.
        e = '{yinv:4'hF, yand:4'h0, yor:4'h0, yxor:4'h0, ynand:4'hF, ynor:4'hF,
              y8:1'b0, ymux:4'h0, ypar:1'b0};
        applyStimulus(1'b0, 4'b0000, 4'h0, 8'h00, 4'h0, 4'h1, 4'h2, 4'h3, 2'd0, e);
        e = '{yinv:4'h0, yand:4'h0, yor:4'hF, yxor:4'hF, ynand:4'hF, ynor:4'h0,
              y8:1'b0, ymux:4'h0, ypar:1'b0};
        applyStimulus(1'b0, 4'b1111, 4'h0, 8'h00, 4'h0, 4'h1, 4'h2, 4'h3, 2'd0, e);
        e = '{yinv:4'b0101, yand:4'h0, yor:4'hA, yxor:4'hA, ynand:4'hF, ynor:4'b0101,
              y8:1'b0, ymux:4'h0, ypar:1'b0};
        applyStimulus(1'b0, 4'b1010, 4'h0, 8'h00, 4'h0, 4'h1, 4'h2, 4'h3, 2'd0, e);

        // Parity vectors (expected ypar follows the build configuration).
        e = '{yinv:4'b0100, yand:4'h0, yor:4'hB, yxor:4'hB, ynand:4'hF, ynor:4'b0100,
              y8:1'b0, ymux:4'h0, ypar:PAR_ON};
        applyStimulus(1'b0, 4'b1011, 4'h0, 8'h00, 4'h0, 4'h1, 4'h2, 4'h3, 2'd0, e);
        e = '{yinv:4'b0110, yand:4'h0, yor:4'h9, yxor:4'h9, ynand:4'hF, ynor:4'b0110,
              y8:1'b0, ymux:4'h0, ypar:1'b0};
        applyStimulus(1'b0, 4'b1001, 4'h0, 8'h00, 4'h0, 4'h1, 4'h2, 4'h3, 2'd0, e);

        // Mid-stream reset discards that cycle's inputs.
        applyStimulus(1'b1, 4'h7, 4'h3, 8'hFF, 4'h0, 4'h1, 4'h2, 4'h3, 2'd2, '0);
        e = '{yinv:4'h8, yand:4'h3, yor:4'h7, yxor:4'h4, ynand:4'hC, ynor:4'h8,
              y8:1'b1, ymux:4'h2, ypar:PAR_ON};
        applyStimulus(1'b0, 4'h7, 4'h3, 8'hFF, 4'h0, 4'h1, 4'h2, 4'h3, 2'd2, e);

        // Exhaustive (a,b) and d8 sweep against the model, with varied mux data.
        for (int i = 0; i < 256; i++) begin
            logic [3:0] va, vb, m0, m1, m2, m3;
            logic [7:0] vd;
            logic [1:0] vs;
            va = i[7:4]; vb = i[3:0]; vd = i[7:0]; vs = i[1:0];
            m0 = i[3:0] ^ 4'h5; m1 = i[7:4]; m2 = ~i[3:0]; m3 = i[5:2];
            applyStimulus(1'b0, va, vb, vd, m0, m1, m2, m3, vs,
                          modelOut(va, vb, vd, m0, m1, m2, m3, vs));
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && expQueue.size() > 0; i++) @(posedge clk);
        #2;
        checkCount++;
        if (expQueue.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d results outstanding, expected 0", expQueue.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
